// File: rtl/laser_tx_frame.sv
// Transmit framer: emits a 25-word emission window holding one run of ones,
// with comma idle words between frames and a send_en window for the receiver.
module laser_tx_frame #(
  parameter int          FRAME_WORDS = 25,
  parameter int          MIN_GAP     = 4,
  parameter logic [15:0] IDLE_WORD   = 16'h50BC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fire_req_i,
  input  logic [8:0]  pulse_start_i,
  input  logic [8:0]  pulse_width_i,
  output logic [15:0] tx_dataout_o,
  output logic [1:0]  tx_k_o,
  output logic        send_en_o,
  output logic        busy_o,
  output logic        fire_drop_o,
  output logic [15:0] frame_cnt_o
);

  localparam int WIW = $clog2(FRAME_WORDS);
  localparam int GW  = $clog2(MIN_GAP + 1);
  localparam logic [9:0] WIN_END = 10'(FRAME_WORDS * 16);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [8:0]     start_q, start_d;
  logic [8:0]     width_q, width_d;
  logic [9:0]     end_q, end_d;
  logic [WIW-1:0] widx_q, widx_d;
  logic [GW-1:0]  gcnt_q, gcnt_d;
  logic [15:0]    tx_q, tx_d;
  logic [1:0]     k_q, k_d;
  logic           en_q, en_d;
  logic           busy_q, busy_d;
  logic           drop_q, drop_d;
  logic [15:0]    cnt_q, cnt_d;

  logic [9:0]  sum;
  logic [9:0]  base;
  logic [15:0] word;

  assign sum  = {1'b0, start_q} + {1'b0, width_q};
  assign base = 10'(widx_q) << 4;

  // Window bit 16w+b is set iff start <= 16w+b < clipped end
  always_comb begin
    word = '0;
    for (int b = 0; b < 16; b++) begin
      word[b] = ({1'b0, start_q} <= base + 10'(b)) &&
                (base + 10'(b) < end_q);
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    width_d = width_q;
    end_d   = end_q;
    widx_d  = widx_q;
    gcnt_d  = gcnt_q;
    tx_d    = IDLE_WORD;
    k_d     = 2'b01;
    en_d    = 1'b0;
    busy_d  = busy_q;
    drop_d  = fire_req_i && busy_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (fire_req_i && !busy_q) begin
          state_d = S_LOAD;
          start_d = pulse_start_i;
          width_d = pulse_width_i;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        end_d   = (sum > WIN_END) ? WIN_END : sum;
        widx_d  = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        tx_d = word;
        k_d  = 2'b00;
        en_d = 1'b1;
        if (widx_q == WIW'(FRAME_WORDS - 1)) begin
          state_d = S_GAP;
          gcnt_d  = '0;
        end else begin
          widx_d = widx_q + WIW'(1);
        end
      end
      S_GAP: begin
        if (gcnt_q == '0) cnt_d = cnt_q + 16'd1;
        if (gcnt_q == GW'(MIN_GAP)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      start_q <= '0;
      width_q <= '0;
      end_q   <= '0;
      widx_q  <= '0;
      gcnt_q  <= '0;
      tx_q    <= IDLE_WORD;
      k_q     <= 2'b01;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      width_q <= width_d;
      end_q   <= end_d;
      widx_q  <= widx_d;
      gcnt_q  <= gcnt_d;
      tx_q    <= tx_d;
      k_q     <= k_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx_dataout_o = tx_q;
  assign tx_k_o       = k_q;
  assign send_en_o    = en_q;
  assign busy_o       = busy_q;
  assign fire_drop_o  = drop_q;
  assign frame_cnt_o  = cnt_q;

endmodule

// File: tb/tb_laser_tx_frame.sv
// Directed bench for laser_tx_frame: frame contents, timing, drops, clipping
// and asynchronous reset.
module tb_laser_tx_frame;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fire = 1'b0;
  logic [8:0]  start_i = '0;
  logic [8:0]  width_i = '0;
  logic [15:0] tx;
  logic [1:0]  txk;
  logic        en;
  logic        busy;
  logic        drop;
  logic [15:0] cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  logic [15:0] cap_tx   [0:34];
  logic [1:0]  cap_k    [0:34];
  logic        cap_en   [0:34];
  logic        cap_busy [0:34];
  logic        cap_drop [0:34];
  logic [15:0] cap_cnt  [0:34];

  laser_tx_frame dut (
    .clk(clk),
    .rst(rst),
    .fire_req_i(fire),
    .pulse_start_i(start_i),
    .pulse_width_i(width_i),
    .tx_dataout_o(tx),
    .tx_k_o(txk),
    .send_en_o(en),
    .busy_o(busy),
    .fire_drop_o(drop),
    .frame_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Fire at E0 (cycle 0); extra fire requests land on edges d1/d2/d3.
  // Inputs are scrambled after accept to show they are not re-sampled.
  task automatic run(input logic [8:0] s, input logic [8:0] w,
                     input int d1, input int d2, input int d3);
    @(negedge clk);
    start_i = s;
    width_i = w;
    fire = 1'b1;
    for (int n = 0; n < 35; n++) begin
      @(posedge clk);
      @(negedge clk);
      cap_tx[n]   = tx;
      cap_k[n]    = txk;
      cap_en[n]   = en;
      cap_busy[n] = busy;
      cap_drop[n] = drop;
      cap_cnt[n]  = cnt;
      if (n + 1 == d1 || n + 1 == d2 || n + 1 == d3) begin
        fire = 1'b1;
        start_i = s;
        width_i = w;
      end else begin
        fire = 1'b0;
        start_i = 9'd0;
        width_i = 9'd300;
      end
    end
    fire = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int i0,
                             input logic [15:0] v0, input int i1,
                             input logic [15:0] v1, input int ndrop);
    int ens;
    int drops;
    logic [15:0] ew;
    for (int k = 0; k < 25; k++) begin
      ew = (k == i0) ? v0 : (k == i1) ? v1 : 16'h0000;
      chk($sformatf("%s.w%0d", tag, k), 32'(cap_tx[2+k]), 32'(ew));
    end
    ens = 0;
    drops = 0;
    for (int n = 0; n <= 30; n++) ens += int'(cap_en[n]);
    for (int n = 0; n <= 33; n++) drops += int'(cap_drop[n]);
    chk({tag, ".en_cnt"}, 32'(ens), 32'd25);
    chk({tag, ".en1"}, 32'(cap_en[1]), 32'd0);
    chk({tag, ".en2"}, 32'(cap_en[2]), 32'd1);
    chk({tag, ".en26"}, 32'(cap_en[26]), 32'd1);
    chk({tag, ".en27"}, 32'(cap_en[27]), 32'd0);
    chk({tag, ".k2"}, 32'(cap_k[2]), 32'd0);
    chk({tag, ".k27"}, 32'(cap_k[27]), 32'd1);
    chk({tag, ".idle27"}, 32'(cap_tx[27]), 32'h50BC);
    chk({tag, ".busy0"}, 32'(cap_busy[0]), 32'd1);
    chk({tag, ".busy30"}, 32'(cap_busy[30]), 32'd1);
    chk({tag, ".busy31"}, 32'(cap_busy[31]), 32'd0);
    chk({tag, ".cnt26"}, 32'(cap_cnt[26]), 32'(exp_cnt));
    chk({tag, ".cnt27"}, 32'(cap_cnt[27]), 32'(exp_cnt + 1));
    chk({tag, ".drops"}, 32'(drops), 32'(ndrop));
    exp_cnt++;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".timeout"}, 32'(n < 100), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst.tx", 32'(tx), 32'h50BC);
    chk("rst.k", 32'(txk), 32'd1);
    chk("rst.en", 32'(en), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.drop", 32'(drop), 32'd0);
    chk("rst.cnt", 32'(cnt), 32'd0);

    // Abort mid-frame with an asynchronous reset just after E12
    @(negedge clk);
    start_i = 9'd0;
    width_i = 9'd400;
    fire = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fire = 1'b0;
    repeat (12) @(posedge clk);
    chk("mid.en", 32'(en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst.tx", 32'(tx), 32'h50BC);
    chk("arst.k", 32'(txk), 32'd1);
    chk("arst.en", 32'(en), 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.cnt", 32'(cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("arst.cnt_hold", 32'(cnt), 32'd0);
    chk("arst.en_hold", 32'(en), 32'd0);

    run(9'd0, 9'd4, -1, -1, -1);
    check_frame("w4", 0, 16'h000F, -1, 16'h0, 0);
    wait_idle("w4");

    run(9'd14, 9'd5, -1, -1, -1);
    check_frame("bnd", 0, 16'hC000, 1, 16'h0007, 0);
    wait_idle("bnd");

    run(9'd390, 9'd50, -1, -1, -1);
    check_frame("clip", 24, 16'hFFC0, -1, 16'h0, 0);
    wait_idle("clip");

    run(9'd400, 9'd10, -1, -1, -1);
    check_frame("off", -1, 16'h0, -1, 16'h0, 0);
    wait_idle("off");

    run(9'd0, 9'd4, 5, 31, 32);
    chk("drop.p5", 32'(cap_drop[5]), 32'd1);
    chk("drop.p31", 32'(cap_drop[31]), 32'd1);
    chk("drop.p32", 32'(cap_drop[32]), 32'd0);
    check_frame("drop", 0, 16'h000F, -1, 16'h0, 2);
    chk("re.busy32", 32'(cap_busy[32]), 32'd1);
    chk("re.en33", 32'(cap_en[33]), 32'd0);
    chk("re.w0", 32'(cap_tx[34]), 32'h000F);
    chk("re.en34", 32'(cap_en[34]), 32'd1);
    wait_idle("re");
    exp_cnt++;
    chk("re.cnt", 32'(cnt), 32'(exp_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/laser_tx_frame.md
# laser_tx_frame

Transmit-side framer for the high-speed transceiver link: on each accepted fire request it emits a 400-bit (200 ns) emission window as 25 consecutive 16-bit words, with `send_en` marking the valid words. The window carries a single run of ones placed by the start-offset and width inputs. Between frames it sends comma idle words. It drives the transceiver TX data path and provides the `send_en` window that the receive-side distance logic gates its capture on.

## Interface
- `FRAME_WORDS`, 25, data words per frame (400 bits / 16)
- `MIN_GAP`, 4, minimum comma words after each frame before the next accept
- `IDLE_WORD`, 16'h50BC, comma idle word (low byte K28.5)
- `clk`  in  1  system clock, single clock domain
- `rst`  in  1  asynchronous, active-high reset
- `fire_req`  in  1  one-cycle fire request
- `pulse_start`  in  9  bit offset of first one within the 400-bit window, latched on accept
- `pulse_width`  in  9  number of one-bits, latched on accept
- `tx_dataout`  out  16  transceiver TX word, registered
- `tx_k`  out  2  K-character flags per byte: 2'b01 on idle words, 2'b00 on data words
- `send_en`  out  1  high exactly while `tx_dataout` carries frame data words
- `busy`  out  1  high from accept until the block can accept again
- `fire_drop`  out  1  one-cycle pulse when `fire_req` is rejected
- `frame_cnt`  out  16  completed-frame counter, wraps 16'hFFFF→0

## Operation
- FSM states: IDLE, LOAD, DATA, GAP.
- IDLE: output `IDLE_WORD`/`tx_k`=2'b01. `fire_req`=1 with `busy`=0 → LOAD. Latch `pulse_start` and `pulse_width`.
- LOAD: compute `end = pulse_start + pulse_width` (10-bit, no overflow) and clip `end` to 400. Clear word index. Go to DATA.
- DATA: word index w = 0..FRAME_WORDS-1. Bit b of word w is 1 iff `pulse_start` ≤ 16w+b < `end`. Bit 0 of word 0 is window bit 0, so the window is sent LSB-first and word 0 first. After word FRAME_WORDS-1: increment `frame_cnt`, go to GAP.
- GAP: send MIN_GAP idle words, then go to IDLE.
- `pulse_width`=0, or `pulse_start` ≥ 400 → all 25 words are 16'h0000. The frame is still sent and still counted.
- A run that extends past bit 399 is truncated. There is no wrap into the next frame.
- `fire_req` while `busy`=1 → `fire_drop`=1 on the next cycle. The current frame and the latched parameters are unaffected. Requests are not queued.
- Input changes after the accept edge have no effect on the frame in flight.
- Reset, asynchronous, at any time including mid-frame: the frame is aborted, the state returns to IDLE and the partial frame is not counted.
- Reset values: `tx_dataout`=IDLE_WORD, `tx_k`=2'b01, `send_en`=0, `busy`=0, `fire_drop`=0, `frame_cnt`=0.

## Timing
- All outputs are registered on `clk` rising edges.
- Accept edge E0: `fire_req`=1 and `busy`=0 sampled at E0.
  - `busy` rises at E0.
  - LOAD occupies E0..E1.
  - Word k is driven from edge E2+k, for k = 0..24, with `send_en`=1 and `tx_k`=2'b00.
- `send_en` falls and idle words resume at E2+FRAME_WORDS (E27).
- `frame_cnt` increments at E27.
- `busy` falls at E2+FRAME_WORDS+MIN_GAP (E31).
- A `fire_req` sampled at E31 is rejected because the pre-edge `busy` was 1. The earliest accept is E32.
- Back-to-back period: 32 cycles with the defaults.
- `fire_drop` is registered: it is high for one cycle following each rejected request edge.
- `send_en` never has gaps inside a frame. It is high for exactly FRAME_WORDS consecutive cycles per accepted request.

## Test plan
- Reset, then 10 idle cycles → `tx_dataout`=16'h50BC, `tx_k`=2'b01, `send_en`=0, `busy`=0, `frame_cnt`=0.
- Fire with start=0, width=4 at E0 → word0=16'h000F at E2, words 1..24=16'h0000, `send_en` high E2..E26, `frame_cnt`=1 at E27, `busy` low at E31.
- Word-boundary run, start=14, width=5 → word0=16'hC000, word1=16'h0007, all other words 0.
- Clipping, start=390, width=50 → word24=16'hFFC0, words 0..23=0. Also start=400, width=10 → all 25 words 0, `frame_cnt` still increments.
- Fire again at E5 and at E31 during the frame → two `fire_drop` pulses, frame contents unchanged; fire at E32 → accepted, word0 at E34.
- Assert `rst` at E12, mid-frame → outputs take their reset values immediately, `frame_cnt` stays 0; a fire after release produces a full 25-word frame.
